ps_event_detector: RTL and testbench
====================================

// Module: ps_event_detector
// PURPOSE
//  Consumer end of the ps feature stream. Takes each windowed power value (dout/data_valid
//  of the ps datapath) and applies a hysteresis threshold with consecutive-window
//  qualification. It raises an alarm and onset/offset pulses to the controller and
//  publishes the per-event peak and a running event count.
// PARAMETERS
//  input_width  40  width of signed feature input, matches ps datapath output_width
//  count_width  8   width of event counter and run counters
//  ON_COUNT     3   consecutive above-thr_on windows needed to raise alarm (1..2^count_width-1)
//  OFF_COUNT    5   consecutive at/below-thr_off windows needed to clear alarm (1..2^count_width-1)
// PORTS
//  clk        in   1            single clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  en         in   1            active-low enable; 1 = freeze all state
//  din        in   input_width  signed feature value
//  din_valid  in   1            din valid this cycle; connect to ps data_valid
//  thr_on     in   input_width  signed onset threshold
//  thr_off    in   input_width  signed release threshold
//  alarm      out  1            level; high in ALARM and DISARMING
//  onset      out  1            one-cycle pulse on QUIET/ARMING->ALARM
//  offset     out  1            one-cycle pulse on DISARMING->QUIET
//  peak       out  input_width  signed max din of last completed event
//  event_cnt  out  count_width  completed events, saturating
//  cfg_err    out  1            registered flag, thr_off > thr_on
// BEHAVIOUR
//  - Reset (async, rst=1): state=QUIET, run=0, work_peak=0, all outputs 0. Takes effect
//    immediately, also mid-event.
//  - Sample accepted only when din_valid=1 and en=0. Every such cycle counts as one window.
//    en=1: no accept, state/counters/peak held, onset/offset forced 0.
//  - Signed compares: hi = din > thr_on; lo = din <= thr_off. If cfg_err, lo uses thr_on.
//    Samples with neither hi nor lo fall in the hysteresis band.
//  - States: QUIET, ARMING, ALARM, DISARMING. run = qualification counter.
//    QUIET: accept & hi -> work_peak=din; go ALARM with onset if ON_COUNT==1,
//      else go ARMING with run=1.
//    ARMING: accept & hi -> run+1 and work_peak=max. When run+1==ON_COUNT -> ALARM,
//      run=0, onset. accept & !hi -> QUIET, run=0.
//    ALARM: accept -> work_peak=max(work_peak,din). If lo: go QUIET with offset when
//      OFF_COUNT==1, else go DISARMING with run=1.
//    DISARMING: accept -> work_peak=max. If lo: run+1; when run+1==OFF_COUNT -> QUIET,
//      run=0, offset. If !lo -> ALARM, run=0.
//  - Completion, on DISARMING->QUIET (or ALARM->QUIET): peak<=work_peak, and
//    event_cnt<=event_cnt+1 unless all ones (saturates, no wrap).
//  - Latency: all outputs registered. onset/alarm rise 1 cycle after the qualifying
//    accept. alarm falls, offset pulses and peak/event_cnt update 1 cycle after the
//    final lo accept.
//  - Pulses: onset and offset are exactly 1 cycle and never both high. With back-to-back
//    accepts, a new event may arm on the cycle after offset.
//  - peak holds between events. An aborted ARMING never changes peak.
//  - Thresholds are sampled each accept, so changing them mid-event is legal.
//    cfg_err updates every cycle regardless of en.
// TESTING
//  1 ON=3,OFF=5,thr_on=1000,thr_off=400. Accept 1200,1500,1100 -> onset 1 clk after 3rd;
//    alarm=1.
//  2 From QUIET accept 1200,1500,900 -> no onset, state QUIET. Then 1001 x3 -> onset.
//  3 In alarm accept 300 x4, then 500 -> alarm stays 1, no offset. Then 300 x5 -> offset
//    1 clk after 5th, alarm=0, event_cnt=1, peak=1500.
//  4 thr_on=-10,thr_off=-50. Accept -5 x3 -> onset. Accept -60 x5 -> offset (signed compare).
//  5 din_valid=1 held with en=1 for 10 clks -> no change; rst pulse in ALARM -> all outputs
//    0 same cycle.
//  6 ON=OFF=1, count_width=8, 260 alternating 2000/0 events -> event_cnt saturates at 255;
//    thr_off=2000,thr_on=1000 -> cfg_err=1.

Source files
------------

// File: rtl/ps_event_detector.sv
// Hysteresis event detector for the ps feature stream: qualifies onset/release over
// consecutive accepted windows and reports alarm level, edge pulses, event peak and count.
module ps_event_detector #(
    parameter int unsigned input_width = 40,
    parameter int unsigned count_width = 8,
    parameter int unsigned ON_COUNT    = 3,
    parameter int unsigned OFF_COUNT   = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic signed [input_width-1:0] din,
    input  logic                          din_valid,
    input  logic signed [input_width-1:0] thr_on,
    input  logic signed [input_width-1:0] thr_off,
    output logic                          alarm,
    output logic                          onset,
    output logic                          offset,
    output logic signed [input_width-1:0] peak,
    output logic [count_width-1:0]        event_cnt,
    output logic                          cfg_err
);

    typedef enum logic [1:0] {StQuiet, StArming, StAlarm, StDisarming} state_e;

    localparam logic [count_width-1:0] OnCnt  = count_width'(ON_COUNT);
    localparam logic [count_width-1:0] OffCnt = count_width'(OFF_COUNT);

    state_e                         state_q, state_d;
    logic [count_width-1:0]         run_q, run_d, run_inc;
    logic signed [input_width-1:0]  work_peak_q, work_peak_d, peak_max, thr_lo;
    logic signed [input_width-1:0]  peak_q, peak_d;
    logic [count_width-1:0]         event_cnt_q, event_cnt_d;
    logic                           alarm_q, alarm_d, onset_q, onset_d, offset_q, offset_d;
    logic                           cfg_err_q, cfg_bad;
    logic                           accept, hi, lo, rise, fall;

    assign accept   = din_valid & ~en;
    assign cfg_bad  = thr_off > thr_on;
    // A mis-ordered threshold pair collapses the band to a single threshold.
    assign thr_lo   = cfg_bad ? thr_on : thr_off;
    assign hi       = din > thr_on;
    assign lo       = din <= thr_lo;
    assign peak_max = (din > work_peak_q) ? din : work_peak_q;
    assign run_inc  = run_q + count_width'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StQuiet;
            run_q       <= '0;
            work_peak_q <= '0;
            alarm_q     <= 1'b0;
            onset_q     <= 1'b0;
            offset_q    <= 1'b0;
            peak_q      <= '0;
            event_cnt_q <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            work_peak_q <= work_peak_d;
            alarm_q     <= alarm_d;
            onset_q     <= onset_d;
            offset_q    <= offset_d;
            peak_q      <= peak_d;
            event_cnt_q <= event_cnt_d;
            cfg_err_q   <= cfg_bad;
        end
    end

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        work_peak_d = work_peak_q;
        rise        = 1'b0;
        fall        = 1'b0;
        if (accept) begin
            unique case (state_q)
                StQuiet: begin
                    if (hi) begin
                        work_peak_d = din;
                        if (ON_COUNT == 1) begin
                            state_d = StAlarm;
                            rise    = 1'b1;
                        end else begin
                            state_d = StArming;
                            run_d   = count_width'(1);
                        end
                    end
                end
                StArming: begin
                    if (hi) begin
                        work_peak_d = peak_max;
                        if (run_inc == OnCnt) begin
                            state_d = StAlarm;
                            run_d   = '0;
                            rise    = 1'b1;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        state_d = StQuiet;
                        run_d   = '0;
                    end
                end
                StAlarm: begin
                    work_peak_d = peak_max;
                    if (lo) begin
                        if (OFF_COUNT == 1) begin
                            state_d = StQuiet;
                            fall    = 1'b1;
                        end else begin
                            state_d = StDisarming;
                            run_d   = count_width'(1);
                        end
                    end
                end
                StDisarming: begin
                    work_peak_d = peak_max;
                    if (lo) begin
                        if (run_inc == OffCnt) begin
                            state_d = StQuiet;
                            run_d   = '0;
                            fall    = 1'b1;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        state_d = StAlarm;
                        run_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        alarm_d     = (state_d == StAlarm) || (state_d == StDisarming);
        onset_d     = rise;
        offset_d    = fall;
        peak_d      = fall ? work_peak_d : peak_q;
        event_cnt_d = event_cnt_q;
        if (fall && (event_cnt_q != '1)) begin
            event_cnt_d = event_cnt_q + count_width'(1);
        end
    end

    assign alarm     = alarm_q;
    assign onset     = onset_q;
    assign offset    = offset_q;
    assign peak      = peak_q;
    assign event_cnt = event_cnt_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_ps_event_detector.sv
// Bench for ps_event_detector: two instances (ON/OFF = 3/5 and 1/1) on shared inputs,
// checked every cycle against a streak-counting reference plus directed literal checks.
module tb_ps_event_detector;

    localparam int IW = 40;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic din_valid = 1'b0;
    logic signed [IW-1:0] din = '0;
    logic signed [IW-1:0] thr_on = '0;
    logic signed [IW-1:0] thr_off = '0;

    logic alarm0, onset0, offset0, cfg0, alarm1, onset1, offset1, cfg1;
    logic signed [IW-1:0] peak0, peak1;
    logic [CW-1:0] cnt0, cnt1;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    ps_event_detector #(.input_width(IW), .count_width(CW), .ON_COUNT(3), .OFF_COUNT(5)) u0 (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .thr_on(thr_on), .thr_off(thr_off), .alarm(alarm0), .onset(onset0),
        .offset(offset0), .peak(peak0), .event_cnt(cnt0), .cfg_err(cfg0)
    );

    ps_event_detector #(.input_width(IW), .count_width(CW), .ON_COUNT(1), .OFF_COUNT(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .thr_on(thr_on), .thr_off(thr_off), .alarm(alarm1), .onset(onset1),
        .offset(offset1), .peak(peak1), .event_cnt(cnt1), .cfg_err(cfg1)
    );

    // Reference: per instance, an in-alarm flag and the length of the current hi (or lo) streak.
    bit                   m_alarm[2], m_onset[2], m_offset[2], m_cfg;
    int                   m_streak[2], m_cnt[2];
    logic signed [IW-1:0] m_wp[2], m_peak[2];

    function automatic int on_n(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic int off_n(input int k);
        return (k == 0) ? 5 : 1;
    endfunction

    task automatic model_reset();
        m_cfg = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_alarm[k] = 1'b0; m_onset[k] = 1'b0; m_offset[k] = 1'b0;
            m_streak[k] = 0; m_cnt[k] = 0; m_wp[k] = '0; m_peak[k] = '0;
        end
    endtask

    task automatic model_step();
        bit acc;
        logic signed [IW-1:0] lt;
        acc = din_valid && !en;
        m_cfg = thr_off > thr_on;
        lt = m_cfg ? thr_on : thr_off;
        for (int k = 0; k < 2; k++) begin
            m_onset[k] = 1'b0;
            m_offset[k] = 1'b0;
            if (!acc) continue;
            if (!m_alarm[k]) begin
                if (din > thr_on) begin
                    if (m_streak[k] == 0 || din > m_wp[k]) m_wp[k] = din;
                    m_streak[k]++;
                    if (m_streak[k] == on_n(k)) begin
                        m_alarm[k] = 1'b1; m_streak[k] = 0; m_onset[k] = 1'b1;
                    end
                end else begin
                    m_streak[k] = 0;
                end
            end else begin
                if (din > m_wp[k]) m_wp[k] = din;
                if (din <= lt) begin
                    m_streak[k]++;
                    if (m_streak[k] == off_n(k)) begin
                        m_alarm[k] = 1'b0; m_streak[k] = 0; m_offset[k] = 1'b1;
                        m_peak[k] = m_wp[k];
                        if (m_cnt[k] < 255) m_cnt[k]++;
                    end
                end else begin
                    m_streak[k] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            chk("alarm0", longint'(alarm0), longint'(m_alarm[0]));
            chk("onset0", longint'(onset0), longint'(m_onset[0]));
            chk("offset0", longint'(offset0), longint'(m_offset[0]));
            chk("peak0", longint'(peak0), longint'(m_peak[0]));
            chk("cnt0", longint'(cnt0), longint'(m_cnt[0]));
            chk("cfg0", longint'(cfg0), longint'(m_cfg));
            chk("alarm1", longint'(alarm1), longint'(m_alarm[1]));
            chk("onset1", longint'(onset1), longint'(m_onset[1]));
            chk("offset1", longint'(offset1), longint'(m_offset[1]));
            chk("peak1", longint'(peak1), longint'(m_peak[1]));
            chk("cnt1", longint'(cnt1), longint'(m_cnt[1]));
            chk("cfg1", longint'(cfg1), longint'(m_cfg));
            chk("pulse_excl0", longint'(onset0 & offset0), 0);
        end
    end

    task automatic step(input logic signed [IW-1:0] d, input bit v, input bit e);
        din = d;
        din_valid = v;
        en = e;
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic acc_n(input int val, input int n);
        for (int i = 0; i < n; i++) step(IW'(val), 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        rst = 1'b0;
        chk_on = 1'b1;
        thr_on = IW'(1000);
        thr_off = IW'(400);
        step('0, 1'b0, 1'b0);
        chk("reset_alarm", longint'(alarm0), 0);
        chk("reset_cnt", longint'(cnt0), 0);

        // Onset after three hi windows
        acc_n(1200, 1);
        acc_n(1500, 1);
        chk("t1_no_early_onset", longint'(onset0), 0);
        acc_n(1100, 1);
        chk("t1_onset", longint'(onset0), 1);
        chk("t1_alarm", longint'(alarm0), 1);

        // Band sample breaks the release streak
        acc_n(300, 4);
        acc_n(500, 1);
        chk("t3_alarm_held", longint'(alarm0), 1);
        chk("t3_no_offset", longint'(offset0), 0);
        acc_n(300, 5);
        chk("t3_offset", longint'(offset0), 1);
        chk("t3_alarm_clr", longint'(alarm0), 0);
        chk("t3_cnt", longint'(cnt0), 1);
        chk("t3_peak", longint'(peak0), 1500);

        // Aborted arming leaves peak alone
        acc_n(1200, 1);
        acc_n(1500, 1);
        acc_n(900, 1);
        chk("t2_quiet", longint'(alarm0), 0);
        chk("t2_peak_kept", longint'(peak0), 1500);
        acc_n(1001, 3);
        chk("t2_onset", longint'(onset0), 1);
        acc_n(300, 5);
        chk("t2_cnt", longint'(cnt0), 2);
        chk("t2_peak", longint'(peak0), 1001);

        // Negative thresholds
        thr_on = IW'(-10);
        thr_off = IW'(-50);
        acc_n(-5, 3);
        chk("t4_onset", longint'(onset0), 1);
        acc_n(-60, 5);
        chk("t4_offset", longint'(offset0), 1);
        chk("t4_peak", longint'(peak0), -5);
        chk("t4_cnt", longint'(cnt0), 3);

        // Freeze, then async reset mid-alarm
        thr_on = IW'(1000);
        thr_off = IW'(400);
        acc_n(1200, 3);
        for (int i = 0; i < 10; i++) step(IW'(300), 1'b1, 1'b1);
        chk("t5_frozen_alarm", longint'(alarm0), 1);
        chk("t5_frozen_cnt", longint'(cnt0), 3);
        rst = 1'b1;
        #1;
        chk("t5_rst_alarm", longint'(alarm0), 0);
        chk("t5_rst_peak", longint'(peak0), 0);
        chk("t5_rst_cnt", longint'(cnt0), 0);
        chk("t5_rst_alarm1", longint'(alarm1), 0);
        model_reset();
        #1;
        rst = 1'b0;

        // cfg_err and counter saturation
        thr_on = IW'(1000);
        thr_off = IW'(2000);
        step('0, 1'b0, 1'b1);
        chk("t6_cfg_err", longint'(cfg0), 1);
        thr_off = IW'(400);
        step('0, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) begin
            acc_n(2000, 1);
            acc_n(0, 1);
        end
        chk("t6_sat", longint'(cnt1), 255);
        chk("t6_peak1", longint'(peak1), 2000);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int v;
            logic signed [IW-1:0] d;
            if ($urandom_range(99) < 3) begin
                thr_on = IW'(int'($urandom_range(1500, 500)));
                thr_off = IW'(int'($urandom_range(1600, 0)));
            end
            v = int'($urandom_range(2400)) - 200;
            d = IW'(v);
            if ($urandom_range(99) < 4) d = IW'({$urandom, $urandom});
            step(d, $urandom_range(99) < 85, $urandom_range(99) < 8);
            if ($urandom_range(999) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
